// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked pipeline stage: occupancy encodings,
// default datapath widths and the stage state type.
package pipe_stage_hs_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_MAIN  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 2;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_MAIN  = OCC_MAIN,
    ST_FULL  = OCC_FULL
  } state_t;

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One beat holder (valid + data + ctrl). Clear drops the beat and zeroes ctrl;
// reset additionally zeroes the data register.
module pipe_stage_hs_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      ctrl_reg  <= in_ctrl;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush.
// Optional perf counters (stall_cnt, flush_cnt) when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = 2,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [1:0]               occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int W = NUM_CH * DATA_W;

  state_t state_reg, state_next;
  logic   in_ready_reg;
  logic   accept, pop, main_from_skid;

  // Index 0 is the main (output-facing) slot, index 1 the skid slot.
  logic [1:0]        slot_load, slot_clear, slot_valid;
  logic [W-1:0]      slot_din  [2];
  logic [W-1:0]      slot_dout [2];
  logic [CTRL_W-1:0] slot_cin  [2];
  logic [CTRL_W-1:0] slot_cout [2];

  always_comb begin
    state_next     = state_reg;
    slot_load      = 2'b00;
    slot_clear     = 2'b00;
    main_from_skid = 1'b0;
    accept         = in_valid & in_ready_reg;
    pop            = slot_valid[0] & out_ready;
    if (flush) begin
      state_next = ST_EMPTY;
      slot_clear = 2'b11;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            slot_load[0] = 1'b1;
            state_next   = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && pop) begin
            slot_load[0] = 1'b1;
          end else if (accept) begin
            slot_load[1] = 1'b1;
            state_next   = ST_FULL;
          end else if (pop) begin
            slot_clear[0] = 1'b1;
            state_next    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            slot_load[0]   = 1'b1;
            main_from_skid = 1'b1;
            slot_clear[1]  = 1'b1;
            state_next     = ST_MAIN;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // in_ready is a pure register so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

  assign slot_din[0] = main_from_skid ? slot_dout[1] : in_data;
  assign slot_cin[0] = main_from_skid ? slot_cout[1] : in_ctrl;
  assign slot_din[1] = in_data;
  assign slot_cin[1] = in_ctrl;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    pipe_stage_hs_slot #(
      .DATA_W(W),
      .CTRL_W(CTRL_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (slot_load[gi]),
      .clear   (slot_clear[gi]),
      .in_data (slot_din[gi]),
      .in_ctrl (slot_cin[gi]),
      .valid   (slot_valid[gi]),
      .data    (slot_dout[gi]),
      .ctrl    (slot_cout[gi])
    );
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = slot_valid[0];
  assign out_data  = slot_dout[0];
  assign out_ctrl  = slot_valid[0] ? slot_cout[0] : '0;
  assign occupancy = state_reg;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (slot_valid[0] && !out_ready && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush && state_reg != ST_EMPTY && flush_cnt_reg != 16'hFFFF)
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: stimulus pushes expected beats, a
// negedge monitor pops and compares every beat the stage hands downstream.
module tb_pipe_stage_hs;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 2;
  localparam int CTRL_W = 2;
  localparam int W = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [W-1:0]      data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  beat_t exp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    mon_beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Monitor: every downstream transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_t e;
      mon_beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {out_data, out_ctrl}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        $display("beat out data=%08h ctrl=%0b (expected %08h/%0b)", out_data, out_ctrl, e.data, e.ctrl);
        check("beat_data", out_data, e.data);
        check("beat_ctrl", out_ctrl, e.ctrl);
      end
    end
  end

  // One clock: record an accepted input beat, then step to just past the edge.
  task automatic cycle(output bit acc);
    acc = in_valid && in_ready && !flush && !rst;
    if (acc) exp_q.push_back('{data: in_data, ctrl: in_ctrl});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int got, gaps, start_beats;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);

    // 1: single beat, latency 1
    in_valid = 1'b1; in_data = {16'h1234, 16'hABCD}; in_ctrl = 2'b11; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    check("t1_accept", acc, 1);
    check("t1_out_valid", out_valid, 1);
    check("t1_occupancy", occupancy, 1);
    idle(2);
    check("t1_drained", occupancy, 0);

    // 2: stall fills skid, C refused until release
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA_0001; in_ctrl = 2'b01; cycle(acc);
    in_data = 32'hBBBB_0002; in_ctrl = 2'b10; cycle(acc);
    in_data = 32'hCCCC_0003; in_ctrl = 2'b11;
    check("t2_occ_full", occupancy, 2);
    check("t2_ready_low", in_ready, 0);
    check("t2_out_is_A", out_data, 32'hAAAA_0001);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cycle(acc);
      if (acc) got = 1;
    end
    check("t2_C_accepted", got, 1);
    in_valid = 1'b0;
    idle(4);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: flush at occ=2 discards held beats and the same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD0D0_0004; in_ctrl = 2'b01; cycle(acc);
    in_data = 32'hE0E0_0005; in_ctrl = 2'b10; cycle(acc);
    check("t3_occ_full", occupancy, 2);
    in_data = 32'hF0F0_0006; in_ctrl = 2'b11; flush = 1'b1; cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("t3_occ", occupancy, 0);
    check("t3_out_valid", out_valid, 0);
    check("t3_out_ctrl", out_ctrl, 0);
    check("t3_ready", in_ready, 1);
    out_ready = 1'b1;
    start_beats = mon_beats;
    idle(3);
    check("t3_no_ghost", mon_beats - start_beats, 0);

    // 4: streaming 100 beats at full rate
    start_beats = mon_beats;
    got = 0; gaps = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = {16'h5000 + 16'(i), 16'h0F00 ^ 16'(i * 3)}; in_ctrl = 2'(i);
      if (i > 0 && !out_valid) gaps++;
      cycle(acc);
      if (acc) got++;
    end
    in_valid = 1'b0;
    idle(3);
    check("t4_accepts", got, 100);
    check("t4_gaps", gaps, 0);
    check("t4_delivered", mon_beats - start_beats, 100);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset mid-operation at occ=1
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h7777_8888; in_ctrl = 2'b11; cycle(acc);
    in_valid = 1'b0;
    check("t5_occ1", occupancy, 1);
    rst = 1'b1; cycle(acc);
    exp_q.delete();
    check("t5_out_valid", out_valid, 0);
    check("t5_occ", occupancy, 0);
    check("t5_out_ctrl", out_ctrl, 0);
    check("t5_out_data", out_data, 0);
    check("t5_ready_low", in_ready, 0);
    cycle(acc);
    check("t5_ready_still_low", in_ready, 0);
    rst = 1'b0; cycle(acc);
    check("t5_ready_back", in_ready, 1);

`ifdef PIPE_STAGE_PERF_EN
    // 6: five stalled cycles then a flush at occ=1
    check("t6_stall_rst", stall_cnt, 0);
    check("t6_flush_rst", flush_cnt, 0);
    in_valid = 1'b1; in_data = 32'h0606_0606; in_ctrl = 2'b01; cycle(acc);
    in_valid = 1'b0;
    idle(4);
    flush = 1'b1; cycle(acc);
    flush = 1'b0;
    exp_q.delete();
    check("t6_stall_cnt", stall_cnt, 5);
    check("t6_flush_cnt", flush_cnt, 1);
    idle(2);
    check("t6_flush_empty_nocount", flush_cnt, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
